// File: rtl/stopwatch_disp_scan.sv
// Time-multiplexed 4-digit 7-segment driver for the stopwatch, showing SS.hh.
// Digits are latched once per frame so a frame never mixes old and new time.
module stopwatch_disp_scan #(
    parameter int SCAN_DIV       = 4,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit DIG_ACTIVE_LOW = 1'b1
) (
    input  logic       clk_1,
    input  logic       rst,
    input  logic [2:0] time_sec_h,
    input  logic [3:0] time_sec_l,
    input  logic [3:0] time_msec_h,
    input  logic [3:0] time_msec_l,
    input  logic       disp_en,
    input  logic       blank_en,
    output logic [6:0] seg,
    output logic       dp,
    output logic [3:0] dig_sel,
    output logic       frame_done
);

    localparam logic [7:0] PRESC_LAST = 8'(SCAN_DIV - 1);
    localparam logic [6:0] SEG_OFF    = {7{SEG_ACTIVE_LOW}};
    localparam logic       DP_OFF     = SEG_ACTIVE_LOW;
    localparam logic [3:0] DIG_OFF    = {4{DIG_ACTIVE_LOW}};

    logic [7:0] presc_reg;
    logic [1:0] idx_reg;
    logic [2:0] snap_sec_h_reg;
    logic [3:0] snap_sec_l_reg;
    logic [3:0] snap_msec_h_reg;
    logic [3:0] snap_msec_l_reg;
    logic [6:0] seg_reg;
    logic       dp_reg;
    logic [3:0] dig_sel_reg;
    logic       frame_done_reg;

    logic       wrap;
    logic       frame_end;
    logic [3:0] cur_val;
    logic       cur_legal;
    logic       blank;
    logic [6:0] seg_lit;
    logic [3:0] dig_lit;
    logic       dp_lit;
    logic [6:0] seg_next;
    logic       dp_next;
    logic [3:0] dig_sel_next;

    function automatic logic [6:0] decode(input logic [3:0] x);
        case (x)
            4'd0:    decode = 7'h3F;
            4'd1:    decode = 7'h06;
            4'd2:    decode = 7'h5B;
            4'd3:    decode = 7'h4F;
            4'd4:    decode = 7'h66;
            4'd5:    decode = 7'h6D;
            4'd6:    decode = 7'h7D;
            4'd7:    decode = 7'h07;
            4'd8:    decode = 7'h7F;
            4'd9:    decode = 7'h6F;
            default: decode = 7'h40;
        endcase
    endfunction

    assign wrap      = (presc_reg == PRESC_LAST);
    assign frame_end = wrap && (idx_reg == 2'd0);

    always_comb begin
        cur_val = 4'd0;
        case (idx_reg)
            2'd3: cur_val = {1'b0, snap_sec_h_reg};
            2'd2: cur_val = snap_sec_l_reg;
            2'd1: cur_val = snap_msec_h_reg;
            2'd0: cur_val = snap_msec_l_reg;
            default: cur_val = 4'd0;
        endcase
    end

    // Tens of seconds only goes to 5; anything above shows a dash.
    assign cur_legal = (idx_reg == 2'd3) ? (cur_val <= 4'd5) : (cur_val <= 4'd9);
    assign blank     = blank_en && (idx_reg == 2'd3) && (snap_sec_h_reg == 3'd0);

    // The first cycle of every slot keeps all digits dark to avoid ghosting.
    for (genvar gi = 0; gi < 4; gi++) begin : g_dig
        assign dig_lit[gi] = disp_en && (idx_reg == 2'(gi)) && (presc_reg != 8'd0);
    end

    always_comb begin
        seg_lit = 7'd0;
        if (disp_en && !blank)
            seg_lit = cur_legal ? decode(cur_val) : 7'h40;
        dp_lit       = disp_en && (idx_reg == 2'd2) && (presc_reg != 8'd0);
        seg_next     = SEG_ACTIVE_LOW ? ~seg_lit : seg_lit;
        dp_next      = SEG_ACTIVE_LOW ? ~dp_lit : dp_lit;
        dig_sel_next = DIG_ACTIVE_LOW ? ~dig_lit : dig_lit;
    end

    always_ff @(posedge clk_1) begin
        if (!rst) begin
            presc_reg       <= 8'd0;
            idx_reg         <= 2'd3;
            snap_sec_h_reg  <= 3'd0;
            snap_sec_l_reg  <= 4'd0;
            snap_msec_h_reg <= 4'd0;
            snap_msec_l_reg <= 4'd0;
            seg_reg         <= SEG_OFF;
            dp_reg          <= DP_OFF;
            dig_sel_reg     <= DIG_OFF;
            frame_done_reg  <= 1'b0;
        end else begin
            presc_reg      <= wrap ? 8'd0 : presc_reg + 8'd1;
            if (wrap)
                idx_reg <= idx_reg - 2'd1;
            frame_done_reg <= frame_end;
            if (frame_end) begin
                snap_sec_h_reg  <= time_sec_h;
                snap_sec_l_reg  <= time_sec_l;
                snap_msec_h_reg <= time_msec_h;
                snap_msec_l_reg <= time_msec_l;
            end
            seg_reg     <= seg_next;
            dp_reg      <= dp_next;
            dig_sel_reg <= dig_sel_next;
        end
    end

    assign seg        = seg_reg;
    assign dp         = dp_reg;
    assign dig_sel    = dig_sel_reg;
    assign frame_done = frame_done_reg;

endmodule

// File: tb/tb_stopwatch_disp_scan.sv
// Scoreboard bench for stopwatch_disp_scan: a frame-position model predicts every
// output cycle; a monitor compares the DUT one tick after each rising edge.
module tb_stopwatch_disp_scan;

    localparam int D     = 4;
    localparam int FRAME = 4 * D;

    logic       clk_1 = 1'b0;
    logic       rst = 1'b0;
    logic [2:0] time_sec_h = '0;
    logic [3:0] time_sec_l = '0;
    logic [3:0] time_msec_h = '0;
    logic [3:0] time_msec_l = '0;
    logic       disp_en = 1'b1;
    logic       blank_en = 1'b0;
    logic [6:0] seg;
    logic       dp;
    logic [3:0] dig_sel;
    logic       frame_done;

    stopwatch_disp_scan #(
        .SCAN_DIV      (D),
        .SEG_ACTIVE_LOW(1'b1),
        .DIG_ACTIVE_LOW(1'b1)
    ) dut (
        .clk_1      (clk_1),
        .rst        (rst),
        .time_sec_h (time_sec_h),
        .time_sec_l (time_sec_l),
        .time_msec_h(time_msec_h),
        .time_msec_l(time_msec_l),
        .disp_en    (disp_en),
        .blank_en   (blank_en),
        .seg        (seg),
        .dp         (dp),
        .dig_sel    (dig_sel),
        .frame_done (frame_done)
    );

    always #5 clk_1 = ~clk_1;

    typedef struct packed {
        logic [6:0] seg;
        logic       dp;
        logic [3:0] dig;
        logic       fd;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;

    // Model state: edges since the last reset, and the digits shown this frame.
    int n = 0;
    int snap[4] = '{0, 0, 0, 0};

    function automatic logic [6:0] glyph(input int v, input int digit);
        if (v > ((digit == 3) ? 5 : 9)) return 7'h40;
        case (v)
            0: return 7'h3F;
            1: return 7'h06;
            2: return 7'h5B;
            3: return 7'h4F;
            4: return 7'h66;
            5: return 7'h6D;
            6: return 7'h7D;
            7: return 7'h07;
            8: return 7'h7F;
            9: return 7'h6F;
            default: return 7'h40;
        endcase
    endfunction

    task automatic step(input logic r, input int sh, input int sl, input int mh, input int ml,
                        input logic de, input logic be);
        exp_t       e;
        int         p, digit, pr;
        logic [6:0] lit;
        logic       lit_dp;
        logic [3:0] lit_dig;
        @(negedge clk_1);
        rst         = r;
        time_sec_h  = 3'(sh);
        time_sec_l  = 4'(sl);
        time_msec_h = 4'(mh);
        time_msec_l = 4'(ml);
        disp_en     = de;
        blank_en    = be;
        if (!r) begin
            e = '{seg: 7'h7F, dp: 1'b1, dig: 4'hF, fd: 1'b0};
            n = 0;
            for (int k = 0; k < 4; k++) snap[k] = 0;
        end else begin
            p       = n % FRAME;
            digit   = 3 - p / D;
            pr      = p % D;
            lit     = 7'd0;
            lit_dp  = 1'b0;
            lit_dig = 4'd0;
            if (de) begin
                if (!(be && digit == 3 && snap[3] == 0))
                    lit = glyph(snap[digit], digit);
                if (pr != 0) begin
                    lit_dig[digit] = 1'b1;
                    lit_dp = (digit == 2);
                end
            end
            e.seg = ~lit;
            e.dp  = ~lit_dp;
            e.dig = ~lit_dig;
            e.fd  = (p == FRAME - 1);
            n++;
            if (e.fd) begin
                snap[3] = sh;
                snap[2] = sl;
                snap[1] = mh;
                snap[0] = ml;
            end
        end
        sb.push_back(e);
    endtask

    always @(posedge clk_1) begin
        #1;
        cyc++;
        if (sb.size() > 0) begin
            mon_e = sb.pop_front();
            checks++;
            if ({seg, dp, dig_sel, frame_done} !== mon_e) begin
                errors++;
                $display("FAIL scan cycle=%0d got seg=%b dp=%b dig_sel=%b frame_done=%b, expected seg=%b dp=%b dig_sel=%b frame_done=%b",
                         cyc, seg, dp, dig_sel, frame_done, mon_e.seg, mon_e.dp, mon_e.dig, mon_e.fd);
            end else begin
                $display("cycle=%0d seg=%b dp=%b dig_sel=%b frame_done=%b ok",
                         cyc, seg, dp, dig_sel, frame_done);
            end
        end
    end

    initial begin
        // Reset held with live inputs 5/9/9/9, then the "00.00" frame and a real frame.
        repeat (3) step(1'b0, 5, 9, 9, 9, 1'b1, 1'b0);
        repeat (2 * FRAME) step(1'b1, 5, 9, 9, 9, 1'b1, 1'b0);
        // Snapshot: msec_l=3 loads, then changes to 7 six cycles into the next frame.
        repeat (FRAME) step(1'b1, 5, 9, 9, 3, 1'b1, 1'b0);
        repeat (6) step(1'b1, 5, 9, 9, 3, 1'b1, 1'b0);
        repeat (2 * FRAME - 6) step(1'b1, 5, 9, 9, 7, 1'b1, 1'b0);
        // Illegal values on sec_h and msec_h.
        repeat (2 * FRAME) step(1'b1, 6, 9, 12, 5, 1'b1, 1'b0);
        repeat (FRAME) step(1'b1, 7, 15, 10, 11, 1'b1, 1'b0);
        // Leading blank on and off.
        repeat (2 * FRAME) step(1'b1, 0, 3, 4, 5, 1'b1, 1'b1);
        repeat (FRAME) step(1'b1, 0, 3, 4, 5, 1'b1, 1'b0);
        // Display off mid-frame, then a mid-frame reset pulse.
        repeat (5) step(1'b1, 1, 2, 3, 4, 1'b1, 1'b0);
        repeat (10) step(1'b1, 1, 2, 3, 4, 1'b0, 1'b0);
        repeat (3) step(1'b1, 1, 2, 3, 4, 1'b1, 1'b0);
        step(1'b0, 1, 2, 3, 4, 1'b1, 1'b0);
        repeat (2 * FRAME + 3) step(1'b1, 1, 2, 3, 4, 1'b1, 1'b0);
        // Randomized: inputs held for random spans, occasional reset and illegal values.
        begin
            int sh, sl, mh, ml, hold;
            logic de, be, r;
            sh = 0; sl = 0; mh = 0; ml = 0; de = 1'b1; be = 1'b0; hold = 0;
            for (int i = 0; i < 800; i++) begin
                if (hold == 0) begin
                    sh   = ($urandom_range(0, 5) == 0) ? int'($urandom_range(6, 7)) : int'($urandom_range(0, 5));
                    sl   = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 9));
                    mh   = int'($urandom_range(0, 9));
                    ml   = ($urandom_range(0, 5) == 0) ? int'($urandom_range(10, 15)) : int'($urandom_range(0, 9));
                    hold = int'($urandom_range(1, 20));
                end
                hold--;
                if ($urandom_range(0, 15) == 0) de = ~de;
                if ($urandom_range(0, 15) == 0) be = ~be;
                r = ($urandom_range(0, 199) != 0);
                step(r, sh, sl, mh, ml, de, be);
            end
        end
        repeat (3) @(negedge clk_1);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d pending entries, expected 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
